// File: rtl/mdom_wvb_hdr_gen.sv
// mdom_wvb_hdr_gen: mDOM waveform-buffer acquisition controller (write address/enable, trigger windows, header record).
// Optional trigger drop counter (drop_cnt/drop_clr) is built when WVB_HDR_DROP_CNT_EN is defined.
module mdom_wvb_hdr_gen #(
    parameter int ADR_W   = 12,
    parameter int LTC_W   = 48,
    parameter int POST_W  = 12,
    parameter int MAX_LEN = 4000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [LTC_W-1:0]  ltc,
    input  logic              thresh_trig,
    input  logic              ext_trig,
    input  logic              sw_trig,
    input  logic              cnst_run_en,
    input  logic              trig_lvl,
    input  logic [4:0]        pre_conf,
    input  logic [POST_W-1:0] post_conf,
    input  logic              hdr_full,
`ifdef WVB_HDR_DROP_CNT_EN
    input  logic              drop_clr,
    output logic [15:0]       drop_cnt,
`endif
    output logic              wvb_wr_en,
    output logic [ADR_W-1:0]  wvb_wr_addr,
    output logic              hdr_wr,
    output logic [LTC_W-1:0]  evt_ltc,
    output logic [ADR_W-1:0]  start_addr,
    output logic [ADR_W-1:0]  stop_addr,
    output logic [1:0]        trig_src,
    output logic              cnst_run,
    output logic [4:0]        pre_conf_o,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_HDR} state_t;

    // Record length can exceed MAX_LEN by up to one post window, so keep headroom.
    localparam int LEN_W = 16;

    state_t            state_q;
    logic [ADR_W-1:0]  addr_q;
    logic [4:0]        fill_q;
    logic [POST_W-1:0] post_q;
    logic [LEN_W-1:0]  len_q;
    logic [LTC_W-1:0]  evt_ltc_q;
    logic [ADR_W-1:0]  start_q;
    logic [ADR_W-1:0]  stop_q;
    logic [1:0]        trig_src_q;
    logic              cnst_run_q;
    logic [4:0]        pre_conf_q;

    logic              trig_any;
    logic              fill_ok;
    logic              accept;
    logic              post_last;
    logic              extend;
    logic [1:0]        src_d;
    logic [LEN_W-1:0]  len_d;

    assign trig_any  = thresh_trig | ext_trig | sw_trig;
    assign fill_ok   = (fill_q >= pre_conf);
    assign accept    = (state_q == S_ARMED) && en && trig_any && fill_ok;
    assign post_last = (post_q <= POST_W'(1));
    assign len_d     = len_q + LEN_W'(1);
    assign extend    = cnst_run_en && trig_lvl && (len_d < LEN_W'(MAX_LEN));
    assign src_d     = sw_trig ? 2'b11 : (ext_trig ? 2'b10 : 2'b01);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            fill_q     <= '0;
            post_q     <= '0;
            len_q      <= '0;
            evt_ltc_q  <= '0;
            start_q    <= '0;
            stop_q     <= '0;
            trig_src_q <= '0;
            cnst_run_q <= 1'b0;
            pre_conf_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en) begin
                        state_q <= S_ARMED;
                        fill_q  <= '0;
                    end
                end
                S_ARMED: begin
                    addr_q <= addr_q + ADR_W'(1);
                    if (!en) begin
                        state_q <= S_IDLE;
                    end else if (accept) begin
                        evt_ltc_q  <= ltc;
                        start_q    <= addr_q - ADR_W'(pre_conf);
                        trig_src_q <= src_d;
                        pre_conf_q <= pre_conf;
                        cnst_run_q <= 1'b0;
                        post_q     <= post_conf;
                        len_q      <= LEN_W'(pre_conf) + LEN_W'(1);
                        // With no post window the trigger sample closes the record.
                        if (post_conf == '0) begin
                            stop_q  <= addr_q;
                            state_q <= S_HDR;
                        end else begin
                            state_q <= S_POST;
                        end
                    end else if (fill_q != 5'd31) begin
                        fill_q <= fill_q + 5'd1;
                    end
                end
                S_POST: begin
                    addr_q <= addr_q + ADR_W'(1);
                    len_q  <= len_d;
                    if (post_last) begin
                        if (extend) begin
                            cnst_run_q <= 1'b1;
                            post_q     <= post_conf;
                        end else begin
                            stop_q  <= addr_q;
                            state_q <= S_HDR;
                        end
                    end else begin
                        post_q <= post_q - POST_W'(1);
                    end
                end
                S_HDR: begin
                    if (!hdr_full) begin
                        if (en) begin
                            state_q <= S_ARMED;
                            fill_q  <= '0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef WVB_HDR_DROP_CNT_EN
    logic [15:0] drop_q;
    logic        drop_ev;

    assign drop_ev = trig_any && ((state_q == S_POST) || (state_q == S_HDR) ||
                                  ((state_q == S_ARMED) && !fill_ok));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (drop_clr) begin
            drop_q <= '0;
        end else if (drop_ev && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_cnt = drop_q;
`endif

    assign wvb_wr_en   = (state_q == S_ARMED) || (state_q == S_POST);
    assign wvb_wr_addr = addr_q;
    assign hdr_wr      = (state_q == S_HDR) && !hdr_full;
    assign evt_ltc     = evt_ltc_q;
    assign start_addr  = start_q;
    assign stop_addr   = stop_q;
    assign trig_src    = trig_src_q;
    assign cnst_run    = cnst_run_q;
    assign pre_conf_o  = pre_conf_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_mdom_wvb_hdr_gen.sv
// Directed testbench for mdom_wvb_hdr_gen; expected addresses are hand-traced from reset.
module tb_mdom_wvb_hdr_gen;
    localparam int ADR_W  = 12;
    localparam int LTC_W  = 48;
    localparam int POST_W = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [LTC_W-1:0]  ltc = '0;
    logic              thresh_trig = 1'b0;
    logic              ext_trig = 1'b0;
    logic              sw_trig = 1'b0;
    logic              cnst_run_en = 1'b0;
    logic              trig_lvl = 1'b0;
    logic [4:0]        pre_conf = '0;
    logic [POST_W-1:0] post_conf = '0;
    logic              hdr_full = 1'b0;
    logic              wvb_wr_en;
    logic [ADR_W-1:0]  wvb_wr_addr;
    logic              hdr_wr;
    logic [LTC_W-1:0]  evt_ltc;
    logic [ADR_W-1:0]  start_addr;
    logic [ADR_W-1:0]  stop_addr;
    logic [1:0]        trig_src;
    logic              cnst_run;
    logic [4:0]        pre_conf_o;
    logic              busy;
`ifdef WVB_HDR_DROP_CNT_EN
    logic              drop_clr = 1'b0;
    logic [15:0]       drop_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mdom_wvb_hdr_gen #(.ADR_W(ADR_W), .LTC_W(LTC_W), .POST_W(POST_W), .MAX_LEN(4000)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ltc(ltc),
        .thresh_trig(thresh_trig), .ext_trig(ext_trig), .sw_trig(sw_trig),
        .cnst_run_en(cnst_run_en), .trig_lvl(trig_lvl),
        .pre_conf(pre_conf), .post_conf(post_conf), .hdr_full(hdr_full),
`ifdef WVB_HDR_DROP_CNT_EN
        .drop_clr(drop_clr), .drop_cnt(drop_cnt),
`endif
        .wvb_wr_en(wvb_wr_en), .wvb_wr_addr(wvb_wr_addr), .hdr_wr(hdr_wr),
        .evt_ltc(evt_ltc), .start_addr(start_addr), .stop_addr(stop_addr),
        .trig_src(trig_src), .cnst_run(cnst_run), .pre_conf_o(pre_conf_o), .busy(busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_tests++;
        if ({wvb_wr_en, wvb_wr_addr, hdr_wr, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctl: wr_en=%0b addr=%0d hdr_wr=%0b busy=%0b, required all 0",
                     wvb_wr_en, wvb_wr_addr, hdr_wr, busy);
        end
        n_tests++;
        if ({evt_ltc, start_addr, stop_addr, trig_src, cnst_run, pre_conf_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_fields: ltc=%h start=%0d stop=%0d src=%b cnst=%0b pre=%0d, required all 0",
                     evt_ltc, start_addr, stop_addr, trig_src, cnst_run, pre_conf_o);
        end
`ifdef WVB_HDR_DROP_CNT_EN
        n_tests++;
        if (drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_drop: drop_cnt=%0d, required 0", drop_cnt);
        end
`endif
        $display("[TB] reset done");
    endtask

    task automatic test_basic;
        int k;
        pre_conf = 5'd4; post_conf = 12'd10; en = 1'b1;
        k = 0;
        while (wvb_wr_addr != 12'd100 && k < 5000) begin tick(); k++; end
        n_tests++;
        if (wvb_wr_addr !== 12'd100) begin
            n_fail++; $display("FAIL basic_wait: addr=%0d, required 100", wvb_wr_addr);
        end
        ltc = 48'h12_3456_789A; thresh_trig = 1'b1;
        tick();
        thresh_trig = 1'b0; ltc = '0;
        k = 1;
        while (!hdr_wr && k < 100) begin tick(); k++; end
        n_tests++;
        if (k != 11 || hdr_wr !== 1'b1) begin
            n_fail++; $display("FAIL basic_latency: cycles=%0d hdr_wr=%0b, required 11 and 1", k, hdr_wr);
        end
        n_tests++;
        if (start_addr !== 12'd96 || stop_addr !== 12'd110 || trig_src !== 2'b01 ||
            cnst_run !== 1'b0 || evt_ltc !== 48'h12_3456_789A || pre_conf_o !== 5'd4) begin
            n_fail++;
            $display("FAIL basic_fields: start=%0d stop=%0d src=%b cnst=%0b ltc=%h pre=%0d, required 96 110 01 0 123456789a 4",
                     start_addr, stop_addr, trig_src, cnst_run, evt_ltc, pre_conf_o);
        end
        tick();
        n_tests++;
        if (hdr_wr !== 1'b0) begin
            n_fail++; $display("FAIL basic_single: hdr_wr=%0b, required 0", hdr_wr);
        end
        $display("[TB] basic record start=%0d stop=%0d", start_addr, stop_addr);
    endtask

    task automatic test_wrap;
        int k;
        pre_conf = 5'd8; post_conf = 12'd4094;
        k = 0;
        while (wvb_wr_addr != 12'd2 && k < 5000) begin tick(); k++; end
        ltc = 48'h0BAD_F00D; ext_trig = 1'b1;
        tick();
        ext_trig = 1'b0; ltc = '0;
        k = 1;
        while (!hdr_wr && k < 5000) begin tick(); k++; end
        n_tests++;
        if (k != 4095 || start_addr !== 12'd4090 || stop_addr !== 12'd0 || trig_src !== 2'b10 ||
            evt_ltc !== 48'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL wrap: cycles=%0d start=%0d stop=%0d src=%b ltc=%h, required 4095 4090 0 10 badf00d",
                     k, start_addr, stop_addr, trig_src, evt_ltc);
        end
        tick();
        $display("[TB] wrap record start=%0d stop=%0d", start_addr, stop_addr);
    endtask

    task automatic test_prefill;
        int k;
        int bad;
        en = 1'b0;
        tick();
        n_tests++;
        if (busy !== 1'b0 || wvb_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL en_off: busy=%0b wr_en=%0b, required 0 0", busy, wvb_wr_en);
        end
        pre_conf = 5'd20; post_conf = 12'd10; en = 1'b1;
        tick();
        repeat (4) tick();
        ltc = 48'hAAA; sw_trig = 1'b1;
        tick();
        sw_trig = 1'b0;
        bad = 0;
        for (int i = 0; i < 19; i++) begin
            if (hdr_wr !== 1'b0) bad++;
            tick();
        end
        n_tests++;
        if (bad != 0 || start_addr !== 12'd4090 || evt_ltc !== 48'h0BAD_F00D || wvb_wr_addr !== 12'd26) begin
            n_fail++;
            $display("FAIL prefill_ignore: hdr_cycles=%0d start=%0d ltc=%h addr=%0d, required 0 4090 badf00d 26",
                     bad, start_addr, evt_ltc, wvb_wr_addr);
        end
        ltc = 48'hBBB; thresh_trig = 1'b1;
        tick();
        thresh_trig = 1'b0;
        k = 1;
        while (!hdr_wr && k < 100) begin tick(); k++; end
        n_tests++;
        if (k != 11 || start_addr !== 12'd6 || stop_addr !== 12'd36 || pre_conf_o !== 5'd20 ||
            evt_ltc !== 48'hBBB || trig_src !== 2'b01) begin
            n_fail++;
            $display("FAIL prefill_accept: cycles=%0d start=%0d stop=%0d pre=%0d ltc=%h src=%b, required 11 6 36 20 bbb 01",
                     k, start_addr, stop_addr, pre_conf_o, evt_ltc, trig_src);
        end
        tick();
        $display("[TB] prefill record start=%0d stop=%0d", start_addr, stop_addr);
    endtask

    task automatic test_backpressure;
        int k;
        int bad;
        int cnt;
        pre_conf = 5'd4; post_conf = 12'd10;
`ifdef WVB_HDR_DROP_CNT_EN
        drop_clr = 1'b1;
`endif
        tick();
`ifdef WVB_HDR_DROP_CNT_EN
        drop_clr = 1'b0;
`endif
        repeat (5) tick();
        hdr_full = 1'b1; ltc = 48'hCCC; ext_trig = 1'b1;
        tick();
        ext_trig = 1'b0;
        k = 1;
        while (wvb_wr_en && k < 100) begin tick(); k++; end
        n_tests++;
        if (k != 11 || busy !== 1'b1 || hdr_wr !== 1'b0) begin
            n_fail++; $display("FAIL bp_enter: cycles=%0d busy=%0b hdr_wr=%0b, required 11 1 0", k, busy, hdr_wr);
        end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            thresh_trig = ((i % 2) == 0);
            if (wvb_wr_en !== 1'b0 || hdr_wr !== 1'b0 || busy !== 1'b1 || start_addr !== 12'd39 ||
                stop_addr !== 12'd53 || evt_ltc !== 48'hCCC || trig_src !== 2'b10) bad++;
            tick();
        end
        thresh_trig = 1'b0;
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL bp_hold: bad_cycles=%0d, required 0", bad);
        end
`ifdef WVB_HDR_DROP_CNT_EN
        n_tests++;
        if (drop_cnt !== 16'd25) begin
            n_fail++; $display("FAIL bp_drop_cnt: drop_cnt=%0d, required 25", drop_cnt);
        end
`endif
        hdr_full = 1'b0;
        #1;
        n_tests++;
        if (hdr_wr !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: hdr_wr=%0b, required 1", hdr_wr);
        end
        tick();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (hdr_wr === 1'b1) cnt++;
            tick();
        end
        n_tests++;
        if (cnt != 0) begin
            n_fail++; $display("FAIL bp_single: extra hdr_wr=%0d, required 0", cnt);
        end
        $display("[TB] backpressure record start=%0d stop=%0d", start_addr, stop_addr);
    endtask

    task automatic test_cnst_priority;
        int k;
        logic [ADR_W-1:0] len;
        pre_conf = 5'd4; post_conf = 12'd10; cnst_run_en = 1'b1; trig_lvl = 1'b1;
        ltc = 48'hDDD; sw_trig = 1'b1; ext_trig = 1'b1; thresh_trig = 1'b1;
        tick();
        sw_trig = 1'b0; ext_trig = 1'b0; thresh_trig = 1'b0;
        repeat (24) tick();
        trig_lvl = 1'b0;
        k = 25;
        while (!hdr_wr && k < 100) begin tick(); k++; end
        len = stop_addr - start_addr + 12'd1;
        n_tests++;
        if (k != 31 || cnst_run !== 1'b1 || start_addr !== 12'd70 || stop_addr !== 12'd104 || len !== 12'd35) begin
            n_fail++;
            $display("FAIL cnst_run: cycles=%0d cnst=%0b start=%0d stop=%0d len=%0d, required 31 1 70 104 35",
                     k, cnst_run, start_addr, stop_addr, len);
        end
        n_tests++;
        if (trig_src !== 2'b11 || evt_ltc !== 48'hDDD) begin
            n_fail++; $display("FAIL priority: src=%b ltc=%h, required 11 ddd", trig_src, evt_ltc);
        end
        cnst_run_en = 1'b0;
        tick();
        $display("[TB] cnst_run record start=%0d stop=%0d", start_addr, stop_addr);
    endtask

    task automatic test_post_zero;
        pre_conf = 5'd5; post_conf = 12'd0;
        repeat (5) tick();
        ltc = 48'hEEE; thresh_trig = 1'b1;
        tick();
        thresh_trig = 1'b0;
        n_tests++;
        if (hdr_wr !== 1'b1 || start_addr !== 12'd105 || stop_addr !== 12'd110 || cnst_run !== 1'b0 ||
            evt_ltc !== 48'hEEE) begin
            n_fail++;
            $display("FAIL post_zero: hdr_wr=%0b start=%0d stop=%0d cnst=%0b ltc=%h, required 1 105 110 0 eee",
                     hdr_wr, start_addr, stop_addr, cnst_run, evt_ltc);
        end
        tick();
        $display("[TB] post_zero record start=%0d stop=%0d", start_addr, stop_addr);
    endtask

    task automatic test_async_reset;
        int k;
        int cnt;
        pre_conf = 5'd0; post_conf = 12'd10;
        ltc = 48'hFFF; sw_trig = 1'b1;
        tick();
        sw_trig = 1'b0;
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({wvb_wr_en, wvb_wr_addr, hdr_wr, evt_ltc, start_addr, stop_addr, trig_src,
             cnst_run, pre_conf_o, busy} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: wr_en=%0b addr=%0d hdr_wr=%0b ltc=%h start=%0d stop=%0d busy=%0b, required all 0",
                     wvb_wr_en, wvb_wr_addr, hdr_wr, evt_ltc, start_addr, stop_addr, busy);
        end
`ifdef WVB_HDR_DROP_CNT_EN
        n_tests++;
        if (drop_cnt !== 16'd0) begin
            n_fail++; $display("FAIL async_drop: drop_cnt=%0d, required 0", drop_cnt);
        end
`endif
        repeat (2) tick();
        rst_n = 1'b1;
        pre_conf = 5'd4;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (hdr_wr === 1'b1) cnt++;
            tick();
        end
        n_tests++;
        if (cnt != 0 || wvb_wr_addr !== 12'd29) begin
            n_fail++; $display("FAIL async_quiet: hdr_wr=%0d addr=%0d, required 0 29", cnt, wvb_wr_addr);
        end
        ltc = 48'h1234; thresh_trig = 1'b1;
        tick();
        thresh_trig = 1'b0;
        k = 1;
        while (!hdr_wr && k < 100) begin tick(); k++; end
        n_tests++;
        if (k != 11 || start_addr !== 12'd25 || stop_addr !== 12'd39 || evt_ltc !== 48'h1234) begin
            n_fail++;
            $display("FAIL async_recover: cycles=%0d start=%0d stop=%0d ltc=%h, required 11 25 39 1234",
                     k, start_addr, stop_addr, evt_ltc);
        end
        $display("[TB] post-reset record start=%0d stop=%0d", start_addr, stop_addr);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_prefill();
        test_backpressure();
        test_cnst_priority();
        test_post_zero();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mdom_wvb_hdr_gen.md
Name: mdom_wvb_hdr_gen

Overview:
- Acquisition controller for one mDOM waveform buffer (WVB) channel.
- Generates the circular-buffer write address and write enable.
- Qualifies triggers, applies pre-trigger and post-trigger windows, and timestamps each record with the local time counter (LTC).
- Emits one header record per waveform: evt_ltc, start_addr, stop_addr, trig_src, cnst_run, pre_conf. These are the exact fields the header bundle packer concatenates into the 80-bit header FIFO word.
- Sits directly upstream of that packer and the header FIFO.

Parameters:
- ADR_W, 12, buffer address width (depth 2^ADR_W = 4096)
- LTC_W, 48, LTC width
- POST_W, 12, post-trigger count width
- MAX_LEN, 4000, maximum samples per record in constant-run extension

Ports:
- clk, input, 1, system clock
- rst_n, input, 1, asynchronous active-low reset
- en, input, 1, acquisition enable (level)
- ltc, input, LTC_W, free-running local time counter
- thresh_trig, input, 1, discriminator trigger (pulse)
- ext_trig, input, 1, external trigger (pulse)
- sw_trig, input, 1, software trigger (pulse)
- cnst_run_en, input, 1, allow record extension while trigger level is held
- trig_lvl, input, 1, trigger level used for constant-run extension
- pre_conf, input, 5, pre-trigger samples (0..31)
- post_conf, input, POST_W, post-trigger samples after the trigger sample
- hdr_full, input, 1, header FIFO full
- wvb_wr_en, output, 1, sample write strobe to the buffer
- wvb_wr_addr, output, ADR_W, sample write address
- hdr_wr, output, 1, one-cycle header write strobe
- evt_ltc, output, LTC_W, LTC captured at the trigger cycle
- start_addr, output, ADR_W, first sample address of the record
- stop_addr, output, ADR_W, last sample address of the record
- trig_src, output, 2, 01 thresh, 10 ext, 11 sw
- cnst_run, output, 1, record was extended
- pre_conf_o, output, 5, pre_conf latched at the trigger
- busy, output, 1, state is not IDLE

Behaviour:
- Reset (async, rst_n low):
  - All outputs 0; state IDLE; wvb_wr_addr 0; fill counter 0.
- States:
  - IDLE: wvb_wr_en 0. Goes to ARMED when en=1; fill counter is cleared on entry.
  - ARMED: wvb_wr_en 1; address increments every cycle and wraps from 2^ADR_W-1 to 0.
    - The fill counter saturates at 31.
    - A trigger is accepted only when fill >= pre_conf. Earlier triggers are ignored.
    - On acceptance:
      - evt_ltc is latched from ltc in that cycle.
      - start_addr = wvb_wr_addr - pre_conf, modulo 2^ADR_W.
      - trig_src is latched; on simultaneous triggers, priority is sw > ext > thresh.
      - pre_conf_o is latched.
      - Post counter is loaded with post_conf; go to POST.
  - POST: wvb_wr_en 1; the post counter decrements each written sample.
    - When it reaches 0, the current address is the last sample.
    - If cnst_run_en=1, trig_lvl=1 and record length < MAX_LEN: stay in POST, set cnst_run, reload post counter with post_conf.
    - Otherwise latch stop_addr = current address and go to HDR.
    - Record length = pre_conf + post_conf + 1 when not extended.
  - HDR: wvb_wr_en 0.
    - If hdr_full=0: hdr_wr=1 for exactly one cycle with all header fields stable in that cycle, then go to ARMED (fill cleared) if en=1, else IDLE.
    - If hdr_full=1: hold in HDR with fields stable; further triggers are dropped.
- Header field timing:
  - Header fields hold their last value until the next trigger acceptance.
  - cnst_run is cleared at each acceptance.
- en deasserted mid-record: the record completes through HDR, then IDLE. en deasserted in ARMED: IDLE next cycle.
- Trigger in POST/HDR: ignored, except as counted under the optional feature.
- Address wrap: stop_addr may be numerically < start_addr; this is legal.
- post_conf=0: stop_addr equals the trigger address.

Optional Feature:
- Macro WVB_HDR_DROP_CNT_EN.
- When defined:
  - Adds output drop_cnt, 16 bits, which counts accepted-type trigger pulses arriving in POST, HDR, or ARMED before fill >= pre_conf. It saturates at 16'hFFFF.
  - Adds input drop_clr, 1 bit, which zeroes the counter synchronously.
  - drop_cnt resets to 0.
- When undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Basic record: pre_conf=4, post_conf=10, thresh_trig at wvb_wr_addr=100 with ltc=0x123456789A.
  - Required: start_addr=96, stop_addr=110, trig_src=01, cnst_run=0, evt_ltc=0x123456789A.
  - hdr_wr pulses once 11 cycles after the trigger.
- Wrap-around: trigger at address 2, pre_conf=8, post_conf=4094.
  - Required: start_addr=4090, stop_addr=0, no error.
- Pre-fill gating: pre_conf=20, trigger 5 cycles after en.
  - Required: no record; a trigger 25 cycles after en is accepted.
- Backpressure: hold hdr_full=1 at record end for 50 cycles while firing triggers.
  - Required: wvb_wr_en=0, fields stable, single hdr_wr after release.
  - With WVB_HDR_DROP_CNT_EN defined, drop_cnt equals the trigger count.
- Constant run and priority:
  - cnst_run_en=1, trig_lvl held for 3 post windows of 10: cnst_run=1, length 31+pre_conf.
  - Simultaneous sw/ext/thresh triggers: trig_src=11.
- Async reset mid-POST: all outputs 0 immediately, IDLE, no hdr_wr after reset release until a new trigger.
